// File: rtl/ram_bist_pkg.sv
// Shared types and constants for the March C- RAM BIST: FSM states, March
// elements and their per-element direction / read / write value tables.
package ram_bist_pkg;

  localparam logic [7:0] DEFAULT_PATTERN = 8'h55;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_RD_CHECK,
    S_FINISH
  } bist_state_t;

  typedef enum logic [2:0] {M0, M1, M2, M3, M4, M5} march_elem_t;

  // Bit i of each table describes element Mi.
  localparam logic [5:0] ELEM_DOWN   = 6'b011000;
  localparam logic [5:0] ELEM_READ   = 6'b111110;
  localparam logic [5:0] ELEM_WRITE  = 6'b011111;
  localparam logic [5:0] ELEM_RD_ONE = 6'b010100;
  localparam logic [5:0] ELEM_WR_ONE = 6'b001010;

  function automatic logic elem_bit(input logic [5:0] tbl, input march_elem_t e);
    return tbl[e];
  endfunction

endpackage

// File: rtl/bist_addr_gen.sv
// Up/down address counter for the March BIST: loads to the first address of an
// element, steps one address per completed address visit, flags the last one.
module bist_addr_gen #(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              load_down,
  input  logic              step,
  input  logic              down,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_down ? '1 : '0;
    end else if (step) begin
      addr <= down ? addr - 1'b1 : addr + 1'b1;
    end
  end

  assign last = down ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/ram_march_bist.sv
// March C- BIST initiator for a single-port synchronous RAM with pass/fail and
// first-failure diagnostics. Optional error counter: RAM_MARCH_BIST_ERRCNT_EN.
module ram_march_bist
  import ram_bist_pkg::*;
#(
  parameter int                ADDR_W       = 7,
  parameter int                DATA_W       = 8,
  parameter int                READ_LATENCY = 1,
  parameter logic [DATA_W-1:0] PATTERN      = DATA_W'(DEFAULT_PATTERN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_got,
  output logic [2:0]        fail_elem,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef RAM_MARCH_BIST_ERRCNT_EN
  ,
  output logic [7:0]        err_count
`endif
);

`ifdef RAM_MARCH_BIST_ERRCNT_EN
  localparam logic ABORT_ON_FAIL = 1'b0;
`else
  localparam logic ABORT_ON_FAIL = 1'b1;
`endif
  localparam logic [1:0] WAIT_LAST = 2'(READ_LATENCY >= 2 ? READ_LATENCY - 2 : 0);

  bist_state_t state;
  march_elem_t elem;
  march_elem_t elem_nxt;
  logic        op_second;
  logic [1:0]  wait_cnt;
  logic        fail_seen;

  logic check_now, mismatch, abort, op_done, last_op, addr_last;
  logic ag_load, ag_load_down, ag_step, ag_down;
  logic [DATA_W-1:0] exp_data, elem_wdata;

  assign elem_nxt   = march_elem_t'(elem + 3'd1);
  assign exp_data   = elem_bit(ELEM_RD_ONE, elem) ? ~PATTERN : PATTERN;
  assign elem_wdata = elem_bit(ELEM_WR_ONE, elem) ? ~PATTERN : PATTERN;

  // With zero latency the read data is compared in the issue cycle itself.
  assign check_now = (state == S_RD_CHECK) || (state == S_RD_ISSUE && READ_LATENCY == 0);
  assign mismatch  = check_now && (mem_rdata != exp_data);
  assign abort     = mismatch && ABORT_ON_FAIL;
  assign op_done   = (state == S_WRITE) || check_now;
  assign last_op   = op_second || !(elem_bit(ELEM_READ, elem) && elem_bit(ELEM_WRITE, elem));

  assign ag_step      = op_done && !abort && last_op && !addr_last;
  assign ag_load      = (state == S_IDLE && start) ||
                        (op_done && !abort && last_op && addr_last && elem != M5);
  assign ag_load_down = (state == S_IDLE) ? 1'b0 : elem_bit(ELEM_DOWN, elem_nxt);
  assign ag_down      = elem_bit(ELEM_DOWN, elem);

  bist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (ag_load),
    .load_down (ag_load_down),
    .step      (ag_step),
    .down      (ag_down),
    .addr      (mem_addr),
    .last      (addr_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      elem      <= M0;
      op_second <= 1'b0;
      wait_cnt  <= '0;
      fail_seen <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_addr <= '0;
      fail_exp  <= '0;
      fail_got  <= '0;
      fail_elem <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
`ifdef RAM_MARCH_BIST_ERRCNT_EN
      err_count <= '0;
`endif
    end else begin
      done <= 1'b0;

      if (mismatch && !fail_seen) begin
        fail_seen <= 1'b1;
        fail_addr <= mem_addr;
        fail_exp  <= exp_data;
        fail_got  <= mem_rdata;
        fail_elem <= elem;
      end
`ifdef RAM_MARCH_BIST_ERRCNT_EN
      if (mismatch && err_count != 8'hFF) err_count <= err_count + 8'd1;
`endif

      case (state)
        S_IDLE: if (start) begin
          busy      <= 1'b1;
          elem      <= M0;
          op_second <= 1'b0;
          pass      <= 1'b0;
          fail_seen <= 1'b0;
          fail_addr <= '0;
          fail_exp  <= '0;
          fail_got  <= '0;
          fail_elem <= '0;
`ifdef RAM_MARCH_BIST_ERRCNT_EN
          err_count <= '0;
`endif
          mem_we    <= 1'b1;
          mem_wdata <= PATTERN;
          state     <= S_WRITE;
        end
        S_RD_ISSUE: begin
          if (READ_LATENCY >= 2) begin
            wait_cnt <= '0;
            state    <= S_RD_WAIT;
          end else if (READ_LATENCY == 1) begin
            state <= S_RD_CHECK;
          end
        end
        S_RD_WAIT: begin
          if (wait_cnt == WAIT_LAST) state <= S_RD_CHECK;
          else                       wait_cnt <= wait_cnt + 2'd1;
        end
        S_FINISH: state <= S_IDLE;
        default: ;
      endcase

      // Sequencing after a completed op: second op of the pair, next address,
      // next element (address already reloaded by the counter), or finish.
      if (op_done) begin
        if (abort) begin
          state  <= S_FINISH;
          busy   <= 1'b0;
          done   <= 1'b1;
          pass   <= 1'b0;
          mem_we <= 1'b0;
        end else if (!last_op) begin
          op_second <= 1'b1;
          state     <= S_WRITE;
          mem_we    <= 1'b1;
          mem_wdata <= elem_wdata;
        end else if (!addr_last) begin
          op_second <= 1'b0;
          if (elem_bit(ELEM_READ, elem)) begin
            state  <= S_RD_ISSUE;
            mem_we <= 1'b0;
          end else begin
            state     <= S_WRITE;
            mem_we    <= 1'b1;
            mem_wdata <= elem_wdata;
          end
        end else if (elem != M5) begin
          elem      <= elem_nxt;
          op_second <= 1'b0;
          state     <= S_RD_ISSUE;
          mem_we    <= 1'b0;
        end else begin
          state  <= S_FINISH;
          busy   <= 1'b0;
          done   <= 1'b1;
          pass   <= !(fail_seen || mismatch);
          mem_we <= 1'b0;
        end
      end
    end
  end

endmodule
